// File: rtl/s_axil_pkg.sv
// Shared encodings for the AXI4-Lite write slave of the DFX sequencer register file.
package s_axil_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_COMMIT  = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  localparam logic [1:0] BANK_SEL_BANK0 = 2'b00;
  localparam logic [1:0] BANK_SEL_BANK1 = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int BANK0_OFF_CONTROL = 0;
  localparam int BANK0_OFF_ENDCNT  = 3;

  // Bit positions inside the bank0 one-hot set vector.
  localparam int BANK0_SET_CONTROL = 0;
  localparam int BANK0_SET_ENDCNT  = 1;
  localparam int BANK0_NUM_SETS    = 2;

  localparam int BANK1_REG_SRC_ADDR = 0;
  localparam int BANK1_REG_SRC_SIZE = 1;
  localparam int BANK1_REG_DES_ADDR = 2;
  localparam int BANK1_REG_DES_SIZE = 3;
  localparam int BANK1_REG_STATUS   = 4;
  localparam int BANK1_REG_PROFILE  = 5;

endpackage

// File: rtl/s_axil_wr_decode.sv
// Combinational write-target decode: address/strobe/lock to bank0/bank1 one-hot selects,
// bank1 slot and an error flag.
module s_axil_wr_decode
  import s_axil_pkg::*;
#(
  parameter int ADDR_WIDTH        = 16,
  parameter int BANK1_INDEX_WIDTH = 2,
  parameter int BANK1_NUM_REGS    = 6,
  parameter int STRB_WIDTH        = 4
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [STRB_WIDTH-1:0]        strb,
  input  logic                         lock,
  output logic [BANK0_NUM_SETS-1:0]    bank0_set,
  output logic [BANK1_NUM_REGS-1:0]    bank1_set,
  output logic [BANK1_INDEX_WIDTH-1:0] slot,
  output logic                         err
);

  localparam int OFF_WIDTH = ADDR_WIDTH - 8;

  logic [1:0]                  bank_sel;
  logic [OFF_WIDTH-1:0]        bank0_off;
  logic [3:0]                  reg_idx;
  logic                        upper_nonzero;
  logic                        reg_in_range;
  logic                        strb_full;
  logic [BANK0_NUM_SETS-1:0]   bank0_hit;
  logic [BANK1_NUM_REGS-1:0]   reg_hit;
  logic                        bank0_ok;
  logic                        bank1_ok;
  logic                        unused_addr_lsbs;

  assign bank_sel         = addr[ADDR_WIDTH-1:ADDR_WIDTH-2];
  assign bank0_off        = addr[ADDR_WIDTH-3:6];
  assign slot             = addr[BANK1_INDEX_WIDTH+5:6];
  assign reg_idx          = addr[5:2];
  assign unused_addr_lsbs = ^addr[1:0];
  assign strb_full        = &strb;
  assign reg_in_range     = ({1'b0, reg_idx} < 5'(BANK1_NUM_REGS));

  // Address bits between the slot field and the bank select must be zero for bank1.
  generate
    if (ADDR_WIDTH - 8 > BANK1_INDEX_WIDTH) begin : g_upper
      assign upper_nonzero = |addr[ADDR_WIDTH-3:BANK1_INDEX_WIDTH+6];
    end else begin : g_no_upper
      assign upper_nonzero = 1'b0;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < BANK1_NUM_REGS; gi++) begin : g_reg_hit
      assign reg_hit[gi] = (reg_idx == 4'(gi));
    end
  endgenerate

  assign bank0_hit[BANK0_SET_CONTROL] = (bank0_off == OFF_WIDTH'(BANK0_OFF_CONTROL));
  assign bank0_hit[BANK0_SET_ENDCNT]  = (bank0_off == OFF_WIDTH'(BANK0_OFF_ENDCNT));

  assign bank0_ok = (bank_sel == BANK_SEL_BANK0) && (|bank0_hit) && strb_full;
  assign bank1_ok = (bank_sel == BANK_SEL_BANK1) && reg_in_range && !upper_nonzero
                    && !lock && strb_full;

  assign err       = !(bank0_ok || bank1_ok);
  assign bank0_set = bank0_ok ? bank0_hit : '0;
  assign bank1_set = bank1_ok ? reg_hit : '0;

endmodule

// File: rtl/s_axil_write_ctrl.sv
// AXI4-Lite write slave: collects AW and W in any order, commits one decoded set pulse,
// then returns OKAY/SLVERR and counts errors.
module s_axil_write_ctrl
  import s_axil_pkg::*;
#(
  parameter int ADDR_WIDTH        = 16,
  parameter int DATA_WIDTH        = 32,
  parameter int BANK1_INDEX_WIDTH = 2,
  parameter int BANK1_NUM_REGS    = 6,
  parameter int ERR_CNT_WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic                         ext_bank1_lock,
  output logic [DATA_WIDTH-1:0]        ext_wr_data,
  output logic [BANK1_INDEX_WIDTH-1:0] ext_bank1_index,
  output logic [BANK1_NUM_REGS-1:0]    ext_bank1_set,
  output logic                         ext_bank0_set_control,
  output logic                         ext_bank0_set_endCnt,
  output logic [ERR_CNT_WIDTH-1:0]     ext_err_cnt
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                       state_reg, state_next;
  logic                         aw_full_reg;
  logic [ADDR_WIDTH-1:0]        aw_addr_reg;
  logic                         w_full_reg;
  logic [DATA_WIDTH-1:0]        w_data_reg;
  logic [STRB_WIDTH-1:0]        w_strb_reg;
  logic [1:0]                   bresp_reg;
  logic [DATA_WIDTH-1:0]        wr_data_reg;
  logic [BANK1_INDEX_WIDTH-1:0] bank1_index_reg;
  logic [ERR_CNT_WIDTH-1:0]     err_cnt_reg;

  logic                         aw_hs;
  logic                         w_hs;
  logic                         in_commit;
  logic                         enter_commit;
  logic [ADDR_WIDTH-1:0]        cur_addr;
  logic [STRB_WIDTH-1:0]        cur_strb;
  logic [DATA_WIDTH-1:0]        cur_data;
  logic [BANK0_NUM_SETS-1:0]    dec_bank0_set;
  logic [BANK1_NUM_REGS-1:0]    dec_bank1_set;
  logic [BANK1_INDEX_WIDTH-1:0] dec_slot;
  logic                         dec_err;

  assign S_AXI_AWREADY = (state_reg == ST_COLLECT) && !aw_full_reg && !reset;
  assign S_AXI_WREADY  = (state_reg == ST_COLLECT) && !w_full_reg && !reset;
  assign S_AXI_BVALID  = (state_reg == ST_RESP);
  assign S_AXI_BRESP   = bresp_reg;

  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign in_commit = (state_reg == ST_COMMIT);

  // Holding register if filled, otherwise the live channel; in COMMIT both are full.
  assign cur_addr = aw_full_reg ? aw_addr_reg : S_AXI_AWADDR;
  assign cur_strb = w_full_reg ? w_strb_reg : S_AXI_WSTRB;
  assign cur_data = w_full_reg ? w_data_reg : S_AXI_WDATA;

  s_axil_wr_decode #(
    .ADDR_WIDTH        (ADDR_WIDTH),
    .BANK1_INDEX_WIDTH (BANK1_INDEX_WIDTH),
    .BANK1_NUM_REGS    (BANK1_NUM_REGS),
    .STRB_WIDTH        (STRB_WIDTH)
  ) u_decode (
    .addr      (cur_addr),
    .strb      (cur_strb),
    .lock      (ext_bank1_lock),
    .bank0_set (dec_bank0_set),
    .bank1_set (dec_bank1_set),
    .slot      (dec_slot),
    .err       (dec_err)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_COLLECT: if ((aw_full_reg || aw_hs) && (w_full_reg || w_hs)) state_next = ST_COMMIT;
      ST_COMMIT:  state_next = ST_RESP;
      ST_RESP:    if (S_AXI_BREADY) state_next = ST_COLLECT;
      default:    state_next = ST_COLLECT;
    endcase
  end

  assign enter_commit = (state_reg == ST_COLLECT) && (state_next == ST_COMMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_COLLECT;
      aw_full_reg     <= 1'b0;
      aw_addr_reg     <= '0;
      w_full_reg      <= 1'b0;
      w_data_reg      <= '0;
      w_strb_reg      <= '0;
      bresp_reg       <= RESP_OKAY;
      wr_data_reg     <= '0;
      bank1_index_reg <= '0;
      err_cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_addr_reg <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= S_AXI_WDATA;
        w_strb_reg <= S_AXI_WSTRB;
      end
      if ((state_reg == ST_RESP) && S_AXI_BREADY) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
      end
      // Data and slot are loaded on the way into COMMIT so they are valid with the pulse.
      if (enter_commit) begin
        wr_data_reg     <= cur_data;
        bank1_index_reg <= dec_slot;
      end
      if (in_commit) begin
        bresp_reg <= dec_err ? RESP_SLVERR : RESP_OKAY;
        if (dec_err && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + 1'b1;
      end
    end
  end

  assign ext_wr_data           = wr_data_reg;
  assign ext_bank1_index       = bank1_index_reg;
  assign ext_err_cnt           = err_cnt_reg;
  assign ext_bank1_set         = in_commit ? dec_bank1_set : '0;
  assign ext_bank0_set_control = in_commit && dec_bank0_set[BANK0_SET_CONTROL];
  assign ext_bank0_set_endCnt  = in_commit && dec_bank0_set[BANK0_SET_ENDCNT];

endmodule

// File: tb/tb_s_axil_write_ctrl.sv
// Scoreboard bench for s_axil_write_ctrl: expected responses and pulses are queued per write
// and compared when the write response handshake completes.
module tb_s_axil_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        lock;
  logic [31:0] wr_data;
  logic [1:0]  bank1_index;
  logic [5:0]  bank1_set;
  logic        set_control;
  logic        set_endcnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  s_axil_write_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .S_AXI_AWADDR          (awaddr),
    .S_AXI_AWVALID         (awvalid),
    .S_AXI_AWREADY         (awready),
    .S_AXI_WDATA           (wdata),
    .S_AXI_WSTRB           (wstrb),
    .S_AXI_WVALID          (wvalid),
    .S_AXI_WREADY          (wready),
    .S_AXI_BRESP           (bresp),
    .S_AXI_BVALID          (bvalid),
    .S_AXI_BREADY          (bready),
    .ext_bank1_lock        (lock),
    .ext_wr_data           (wr_data),
    .ext_bank1_index       (bank1_index),
    .ext_bank1_set         (bank1_set),
    .ext_bank0_set_control (set_control),
    .ext_bank0_set_endCnt  (set_endcnt),
    .ext_err_cnt           (err_cnt)
  );

  typedef struct packed {
    logic [1:0]  b0;
    logic [5:0]  b1;
    logic [1:0]  idx;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  logic [1:0]  seen_b0;
  logic [5:0]  seen_b1;
  logic [1:0]  seen_idx;
  logic [31:0] seen_data;
  int          pulse_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    else pass_cnt++;
  endtask

  // Pulses are accumulated between responses; each response closes one write.
  always @(negedge clk) begin
    if (reset) begin
      seen_b0 = '0; seen_b1 = '0; seen_idx = '0; seen_data = '0; pulse_cycles = 0;
    end else begin
      if (set_control || set_endcnt || (|bank1_set)) begin
        pulse_cycles++;
        seen_b0   = seen_b0 | {set_endcnt, set_control};
        seen_b1   = seen_b1 | bank1_set;
        seen_idx  = bank1_index;
        seen_data = wr_data;
      end
      if (bvalid && bready) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          $display("write resp=%0d bank0=%b bank1=%b idx=%0d data=0x%0h",
                   bresp, seen_b0, seen_b1, seen_idx, seen_data);
          check("bresp", 32'(bresp), 32'(mon_exp.resp));
          check("bank0_pulse", 32'(seen_b0), 32'(mon_exp.b0));
          check("bank1_pulse", 32'(seen_b1), 32'(mon_exp.b1));
          check("pulse_cycles", pulse_cycles, ((mon_exp.b0 != 0) || (mon_exp.b1 != 0)) ? 1 : 0);
          if (mon_exp.b1 != 0) check("bank1_index", 32'(seen_idx), 32'(mon_exp.idx));
          if ((mon_exp.b0 != 0) || (mon_exp.b1 != 0)) check("wr_data", seen_data, mon_exp.data);
        end
        seen_b0 = '0; seen_b1 = '0; seen_idx = '0; seen_data = '0; pulse_cycles = 0;
      end
    end
  end

  task automatic send_aw(input logic [15:0] a);
    int n;
    awaddr = a; awvalid = 1'b1; n = 0;
    @(negedge clk);
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (!awready) check("aw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n;
    wdata = d; wstrb = s; wvalid = 1'b1; n = 0;
    @(negedge clk);
    while (!wready && n < 100) begin @(negedge clk); n++; end
    if (!wready) check("w_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] b0, input logic [5:0] b1, input logic [1:0] idx,
                          input logic [1:0] resp);
    exp_t e;
    e.b0 = b0; e.b1 = b1; e.idx = idx; e.data = d; e.resp = resp;
    exp_q.push_back(e);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; awaddr = '0; wdata = '0; wstrb = '0;
    bready = 1'b1; lock = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_pulses", {set_endcnt, set_control, bank1_set}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_index", 32'(bank1_index), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_awready", 32'(awready), 32'd1);
    check("post_rst_wready", 32'(wready), 32'd1);
    @(posedge clk); #1;

    // Same-cycle AW+W to slot 2 des_addr: pulse at T+1, BVALID at T+2, READY back at T+3.
    exp_q.push_back('{b0: 2'b00, b1: 6'b000100, idx: 2'd2, data: 32'hDEADBEEF, resp: 2'b00});
    awaddr = 16'h4088; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("t1_awready", 32'(awready), 32'd1);
    check("t1_wready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("t1_set", 32'(bank1_set), 32'b000100);
    check("t1_index", 32'(bank1_index), 32'd2);
    check("t1_data", wr_data, 32'hDEADBEEF);
    check("t1_bvalid_early", 32'(bvalid), 32'd0);
    @(negedge clk);
    check("t1_bvalid", 32'(bvalid), 32'd1);
    check("t1_bresp", 32'(bresp), 32'd0);
    check("t1_set_gone", 32'(bank1_set), 32'd0);
    check("t1_awready_busy", 32'(awready), 32'd0);
    @(negedge clk);
    check("t1_awready_back", 32'(awready), 32'd1);
    check("t1_bvalid_gone", 32'(bvalid), 32'd0);
    @(posedge clk); #1;

    // W first, AW three cycles later.
    exp_q.push_back('{b0: 2'b01, b1: 6'b0, idx: 2'd0, data: 32'h5, resp: 2'b00});
    send_w(32'h5, 4'hF);
    @(negedge clk);
    check("t2_wready_drop", 32'(wready), 32'd0);
    check("t2_awready", 32'(awready), 32'd1);
    check("t2_no_pulse", 32'(set_control), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send_aw(16'h0000);
    @(negedge clk);
    check("t2_control", 32'(set_control), 32'd1);
    check("t2_endcnt", 32'(set_endcnt), 32'd0);
    check("t2_data", wr_data, 32'h5);
    wait_idle();

    // Unmapped bank, out-of-range register, partial strobe.
    do_write(16'h8000, 32'h11, 4'hF, 2'b00, 6'b0, 2'd0, 2'b10);
    do_write(16'h4018, 32'h22, 4'hF, 2'b00, 6'b0, 2'd0, 2'b10);
    do_write(16'h4000, 32'h33, 4'h3, 2'b00, 6'b0, 2'd0, 2'b10);
    wait_idle();
    check("t3_err_cnt", 32'(err_cnt), 32'd3);

    // Locked bank1 write rejected, accepted once unlocked.
    lock = 1'b1;
    do_write(16'h4004, 32'hA5A5, 4'hF, 2'b00, 6'b0, 2'd0, 2'b10);
    wait_idle();
    check("t4_err_cnt", 32'(err_cnt), 32'd4);
    lock = 1'b0;
    do_write(16'h4004, 32'hA5A5, 4'hF, 2'b00, 6'b000010, 2'd0, 2'b00);
    wait_idle();

    // Other targets: endCnt, slot 3 profile (addr[1:0] ignored), slot 1 src_addr, and errors.
    do_write(16'h00C0, 32'h77, 4'hF, 2'b10, 6'b0, 2'd0, 2'b00);
    do_write(16'h40D7, 32'h99, 4'hF, 2'b00, 6'b100000, 2'd3, 2'b00);
    do_write(16'h4040, 32'h1234, 4'hF, 2'b00, 6'b000001, 2'd1, 2'b00);
    do_write(16'h0040, 32'h44, 4'hF, 2'b00, 6'b0, 2'd0, 2'b10);
    do_write(16'h4100, 32'h55, 4'hF, 2'b00, 6'b0, 2'd0, 2'b10);
    do_write(16'hC000, 32'h66, 4'hF, 2'b00, 6'b0, 2'd0, 2'b10);
    wait_idle();
    check("t5_err_cnt", 32'(err_cnt), 32'd7);

    // Backpressure on B: response held stable, no new address accepted.
    bready = 1'b0;
    do_write(16'h4044, 32'hCAFE, 4'hF, 2'b00, 6'b000010, 2'd1, 2'b00);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_bvalid", 32'(bvalid), 32'd1);
      check("hold_bresp", 32'(bresp), 32'd0);
      check("hold_awready", 32'(awready), 32'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_idle();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) do_write(16'h8000, i, 4'hF, 2'b00, 6'b0, 2'd0, 2'b10);
    wait_idle();
    check("sat_err_cnt", 32'(err_cnt), 32'd255);

    // Reset with only AW captured: write is dropped.
    send_aw(16'h4000);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_awready", 32'(awready), 32'd0);
    check("mid_rst_wready", 32'(wready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_awready", 32'(awready), 32'd1);
    check("t6_wready", 32'(wready), 32'd1);
    check("t6_err_cnt", 32'(err_cnt), 32'd0);
    check("t6_wr_data", wr_data, 32'd0);
    @(posedge clk); #1;
    send_w(32'h1234_5678, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_bvalid", 32'(bvalid), 32'd0);
      check("t6_pulses", {set_endcnt, set_control, bank1_set}, 32'd0);
    end
    check("q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/s_axil_write_ctrl.md
# s_axil_write_ctrl

Parametrised AXI4-Lite write slave for the DFX sequencer register file, successor to the single-state-machine write port. Accepts AW and W independently and in either order, decodes the target into bank0 (sequencer control) or bank1 (slot table, `2^BANK1_INDEX_WIDTH` slots × `BANK1_NUM_REGS` registers), and issues a one-cycle set pulse with registered data. It returns SLVERR for unmapped, partial-strobe or locked writes, and counts the errors. It sits between the PS AXI-Lite interconnect and the bank0/bank1 storage blocks.

## Interface
- `ADDR_WIDTH`, 16, AXI address width; must be ≥ `BANK1_INDEX_WIDTH`+8.
- `DATA_WIDTH`, 32, AXI data width; only 32 is supported.
- `BANK1_INDEX_WIDTH`, 2, slot index width.
- `BANK1_NUM_REGS`, 6, registers per slot; range 1..16.
- `ERR_CNT_WIDTH`, 8, width of the saturating error counter.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `S_AXI_AWADDR`/`S_AXI_AWVALID`/`S_AXI_AWREADY`  in/in/out  `ADDR_WIDTH`/1/1  write address channel.
- `S_AXI_WDATA`/`S_AXI_WSTRB`/`S_AXI_WVALID`/`S_AXI_WREADY`  in/in/in/out  `DATA_WIDTH`/`DATA_WIDTH/8`/1/1  write data channel.
- `S_AXI_BRESP`/`S_AXI_BVALID`/`S_AXI_BREADY`  out/out/in  2/1/1  write response channel.
- `ext_bank1_lock`  in  1  high while the sequencer is running; bank1 writes are rejected.
- `ext_wr_data`  out  `DATA_WIDTH`  registered write data, valid whenever any set pulse is high.
- `ext_bank1_index`  out  `BANK1_INDEX_WIDTH`  target slot.
- `ext_bank1_set`  out  `BANK1_NUM_REGS`  one-hot register set pulse (bit 0 src_addr, 1 src_size, 2 des_addr, 3 des_size, 4 status, 5 profile).
- `ext_bank0_set_control`/`ext_bank0_set_endCnt`  out  1/1  bank0 set pulses.
- `ext_err_cnt`  out  `ERR_CNT_WIDTH`  count of SLVERR responses, saturating.

## Operation
- States:
  - COLLECT: AW and W are each captured into a holding register with a full flag. `AWREADY` = COLLECT & !aw_full; `WREADY` = COLLECT & !w_full.
  - COMMIT: lasts one cycle. Entered when (aw_full | AW handshake) & (w_full | W handshake).
  - RESP: `BVALID`=1 with `BRESP` held stable. Returns to COLLECT on `BREADY`, which clears both flags.
- Decode in COMMIT, bank select = `addr[ADDR_WIDTH-1:ADDR_WIDTH-2]`:
  - 00 → bank0: `addr[ADDR_WIDTH-3:6]`=0 sets control, =3 sets endCnt; any other value is an error.
  - 01 → bank1: slot = `addr[BANK1_INDEX_WIDTH+5:6]`, reg = `addr[5:2]`. Error if reg ≥ `BANK1_NUM_REGS`, if any bit of `addr[ADDR_WIDTH-3:BANK1_INDEX_WIDTH+6]` is nonzero, or if `ext_bank1_lock`=1 in the COMMIT cycle.
  - 10, 11 → error.
  - `addr[1:0]` is ignored.
- `WSTRB` ≠ all-ones → error, because the banks do not merge bytes.
- On error: no set pulse, `BRESP`=2'b10, and `ext_err_cnt` increments (saturating at all-ones). Otherwise `BRESP`=2'b00.
- Exactly one set pulse, or none, per write.

## Timing
- Reset values:
  - AWREADY/WREADY: 0 during reset, 1 in the first cycle after reset.
  - BVALID: 0.
  - BRESP: 00.
  - All set pulses: 0.
  - `ext_wr_data`: 0.
  - `ext_bank1_index`: 0.
  - `ext_err_cnt`: 0.
- Latency:
  - AW and W both handshaken in cycle T → COMMIT (set pulse) in T+1 → BVALID in T+2.
  - With BREADY high at T+2, AWREADY/WREADY reassert at T+3.
  - Peak rate is one write per 3 cycles.
- AW before W (or W before AW): the early channel's READY drops the cycle after its handshake; COMMIT follows the later handshake by one cycle.
- Set pulses, `ext_wr_data` and `ext_bank1_index` are driven only in COMMIT; data and index hold their values afterwards.
- BVALID holds until BREADY; BREADY asserted while BVALID is low is ignored.
- Reset asserted in any state returns the block to COLLECT the next cycle. A write still in flight is dropped with no pulse and no response. A pulse already issued in COMMIT is not retracted.

## Structure
- Package `s_axil_pkg`: state encoding, bank-select codes, BRESP codes (OKAY=2'b00, SLVERR=2'b10), bank0 offsets (CONTROL=0, ENDCNT=3), and bank1 register-index constants.
- Sub-module `s_axil_wr_decode`: purely combinational. Maps (addr, strb, lock) to {bank0 one-hot, bank1 one-hot, slot, err}. The top level holds the FSM, holding registers and error counter.

## Test plan
- AW 0x4088 and W 0xDEADBEEF/strb 0xF in the same cycle T → `ext_bank1_set`=6'b000100 and `ext_bank1_index`=2 at T+1; BVALID with BRESP 00 at T+2.
- W 0x5 presented 3 cycles before AW 0x0000 → WREADY low after the W handshake; `ext_bank0_set_control` pulses one cycle after the AW handshake with `ext_wr_data`=5.
- AW 0x8000 (bank 10), then AW 0x4018 (reg 6), then strb 0x3 → each gives BRESP 10 with no pulse; `ext_err_cnt` ends at 3.
- `ext_bank1_lock`=1 with a write to 0x4004 → SLVERR, no pulse; the same write after lock drops → `ext_bank1_set`[1] pulses.
- BREADY held low for 10 cycles → BVALID and BRESP stable for all 10 cycles, AWREADY low throughout; 300 error writes → `ext_err_cnt` saturates at 255.
- Reset asserted after the AW handshake but before W → no pulse, no BVALID; AWREADY=1 the cycle after reset deasserts.
